// File: rtl/packet_pkg.sv
// Shared packet definitions for the switch fabric and its egress queues.
// Widths, the packed packet bundle and the one-hot port addresses live here.
package packet_pkg;

  localparam int ADDR_WIDTH    = 4;
  localparam int PAYLOAD_WIDTH = 8;
  localparam int PKT_WIDTH     = PAYLOAD_WIDTH + 2 * ADDR_WIDTH;

  typedef struct packed {
    logic [PAYLOAD_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0]    target;
    logic [ADDR_WIDTH-1:0]    source;
  } pkt_t;

  localparam logic [ADDR_WIDTH-1:0] PORT0_ADDR = 4'b0001;
  localparam logic [ADDR_WIDTH-1:0] PORT1_ADDR = 4'b0010;
  localparam logic [ADDR_WIDTH-1:0] PORT2_ADDR = 4'b0100;
  localparam logic [ADDR_WIDTH-1:0] PORT3_ADDR = 4'b1000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a separate level counter.
// A push is accepted when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LVL_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
    else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is defined solely by level_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/switch_egress_queue.sv
// Per-port egress buffer: classifies switch output packets, queues matching
// ones, and counts overflow drops and misroutes with saturating counters.
module switch_egress_queue #(
  parameter int                       ADDR_WIDTH    = packet_pkg::ADDR_WIDTH,
  parameter int                       PAYLOAD_WIDTH = packet_pkg::PAYLOAD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]    PORT_ADDR     = packet_pkg::PORT0_ADDR,
  parameter int                       DEPTH         = 4,
  parameter int                       CNT_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [ADDR_WIDTH-1:0]      source_in,
  input  logic [ADDR_WIDTH-1:0]      target_in,
  input  logic [PAYLOAD_WIDTH-1:0]   data_in,
  input  logic                       out_ready,
  input  logic                       clr_cnt,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_source,
  output logic [ADDR_WIDTH-1:0]      out_target,
  output logic [PAYLOAD_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic [CNT_WIDTH-1:0]       misroute_cnt
);

  localparam int PKT_W = PAYLOAD_WIDTH + 2 * ADDR_WIDTH;

  logic                 addr_match;
  logic                 is_misroute;
  logic                 is_overflow;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PKT_W-1:0]     fifo_wdata;
  logic [PKT_W-1:0]     fifo_rdata;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] misroute_cnt_q, misroute_cnt_d;

  // Misroute is decided on the address alone, before any fullness check.
  always_comb begin
    addr_match  = (target_in == PORT_ADDR);
    fifo_pop    = out_ready && !fifo_empty;
    is_misroute = valid_in && !addr_match;
    fifo_push   = valid_in && addr_match && (!fifo_full || fifo_pop);
    is_overflow = valid_in && addr_match && fifo_full && !fifo_pop;
    fifo_wdata  = {data_in, target_in, source_in};
  end

  always_comb begin
    drop_cnt_d     = drop_cnt_q;
    misroute_cnt_d = misroute_cnt_q;
    if (clr_cnt) begin
      drop_cnt_d     = '0;
      misroute_cnt_d = '0;
    end else begin
      if (is_overflow && (drop_cnt_q != '1))
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      if (is_misroute && (misroute_cnt_q != '1))
        misroute_cnt_d = misroute_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q     <= '0;
      misroute_cnt_q <= '0;
    end else begin
      drop_cnt_q     <= drop_cnt_d;
      misroute_cnt_q <= misroute_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid    = !fifo_empty;
  assign out_data     = fifo_rdata[PKT_W-1 -: PAYLOAD_WIDTH];
  assign out_target   = fifo_rdata[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign out_source   = fifo_rdata[ADDR_WIDTH-1:0];
  assign full         = fifo_full;
  assign empty        = fifo_empty;
  assign drop_cnt     = drop_cnt_q;
  assign misroute_cnt = misroute_cnt_q;

endmodule

// File: tb/tb_switch_egress_queue.sv
// Scoreboard bench for switch_egress_queue serving port address 4'b0010.
module tb_switch_egress_queue;

  localparam logic [3:0] PORT  = 4'b0010;
  localparam int         DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] source_in;
  logic [3:0] target_in;
  logic [7:0] data_in;
  logic       out_ready;
  logic       clr_cnt;
  logic       out_valid;
  logic [3:0] out_source;
  logic [3:0] out_target;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic [7:0] drop_cnt;
  logic [7:0] misroute_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] sb[$];
  int          mdrop = 0;
  int          mmis  = 0;

  switch_egress_queue #(
    .ADDR_WIDTH    (4),
    .PAYLOAD_WIDTH (8),
    .PORT_ADDR     (PORT),
    .DEPTH         (DEPTH),
    .CNT_WIDTH     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .source_in    (source_in),
    .target_in    (target_in),
    .data_in      (data_in),
    .out_ready    (out_ready),
    .clr_cnt      (clr_cnt),
    .out_valid    (out_valid),
    .out_source   (out_source),
    .out_target   (out_target),
    .out_data     (out_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .drop_cnt     (drop_cnt),
    .misroute_cnt (misroute_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance the reference model by one cycle using the inputs currently driven,
  // then step to 1 time unit after the next rising edge.
  task automatic tick();
    bit pop_m;
    pop_m = (sb.size() > 0) && out_ready;
    if (pop_m) void'(sb.pop_front());
    if (valid_in && target_in == PORT) begin
      if (sb.size() < DEPTH) sb.push_back({data_in, target_in, source_in});
      else if (!clr_cnt && mdrop < 255) mdrop++;
    end
    if (valid_in && target_in != PORT && !clr_cnt && mmis < 255) mmis++;
    if (clr_cnt) begin
      mdrop = 0;
      mmis  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] src, input logic [3:0] tgt,
                       input logic [7:0] d);
    valid_in  = v;
    source_in = src;
    target_in = tgt;
    data_in   = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'b0001, PORT, 8'h00);
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    n_cmp++; if (drop_cnt !== 8'd0 || misroute_cnt !== 8'd0) begin n_err++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", drop_cnt, misroute_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_flow();
    logic [15:0] exp;
    out_ready = 1'b1;
    drive(1'b1, 4'b0001, 4'b0010, 8'hA5);
    tick();
    drive(1'b0, 4'b0001, 4'b0010, 8'h00);
    exp = 16'hA521;
    n_cmp++; if (sb.size() != 1 || sb[0] !== exp) begin n_err++; $display("[TB] FAIL basic_model: scoreboard size %0d", sb.size()); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
    n_cmp++; if ({out_data, out_target, out_source} !== exp) begin n_err++; $display("[TB] FAIL basic_fields: got %h expected %h", {out_data, out_target, out_source}, exp); end
    tick();
    n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL basic_drained: got empty=%b valid=%b expected 1/0", empty, out_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] exp;
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 4'b0100, PORT, 8'(i));
      tick();
    end
    drive(1'b0, 4'b0100, PORT, 8'h00);
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("[TB] FAIL fill_level: got %0d expected 4", level); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("[TB] FAIL fill_drop_cnt: got %0d expected 2", drop_cnt); end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      exp = sb[0];
      n_cmp++; if (out_valid !== 1'b1 || {out_data, out_target, out_source} !== exp) begin n_err++; $display("[TB] FAIL fill_drain: got valid=%b pkt=%h expected pkt=%h", out_valid, {out_data, out_target, out_source}, exp); end
      tick();
    end
    n_cmp++; if (sb.size() != 0 || empty !== 1'b1) begin n_err++; $display("[TB] FAIL fill_drain_done: got empty=%b, %0d left in model", empty, sb.size()); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("[TB] FAIL fill_clear: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_push_pop_full();
    logic [15:0] exp;
    logic [7:0]  order [4];
    order[0] = 8'd2; order[1] = 8'd3; order[2] = 8'd4; order[3] = 8'd9;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'b1000, PORT, 8'(i));
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 4'b1000, PORT, 8'd9);
    tick();
    drive(1'b0, 4'b1000, PORT, 8'h00);
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("[TB] FAIL pushpop_level: got %0d expected 4", level); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("[TB] FAIL pushpop_drop: got %0d expected 0", drop_cnt); end
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      exp = sb[0];
      n_cmp++; if (out_valid !== 1'b1 || {out_data, out_target, out_source} !== exp) begin n_err++; $display("[TB] FAIL pushpop_drain: got valid=%b pkt=%h expected pkt=%h", out_valid, {out_data, out_target, out_source}, exp); end
      if (k < 4) begin
        n_cmp++; if (out_data !== order[k]) begin n_err++; $display("[TB] FAIL pushpop_order: got %0d expected %0d", out_data, order[k]); end
      end
      tick();
    end
    n_cmp++; if (sb.size() != 0 || empty !== 1'b1) begin n_err++; $display("[TB] FAIL pushpop_done: got empty=%b, %0d left in model", empty, sb.size()); end
  endtask

  task automatic test_misroute_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 4'b0100, 8'(8'h30 + i));
      tick();
    end
    n_cmp++; if (misroute_cnt !== 8'd3) begin n_err++; $display("[TB] FAIL misroute_cnt: got %0d expected 3", misroute_cnt); end
    n_cmp++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL misroute_level: got level=%0d valid=%b expected 0/0", level, out_valid); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    drive(1'b0, 4'b0001, PORT, 8'h00);
    n_cmp++; if (misroute_cnt !== 8'd0) begin n_err++; $display("[TB] FAIL misroute_clear: got %0d expected 0", misroute_cnt); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 300; i++) begin
      drive(1'b1, 4'b0001, PORT, 8'(i));
      tick();
    end
    drive(1'b0, 4'b0001, PORT, 8'h00);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("[TB] FAIL sat_drop: got %0d expected 255", drop_cnt); end
    n_cmp++; if (mdrop != 255) begin n_err++; $display("[TB] FAIL sat_model: got %0d expected 255", mdrop); end
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      exp = sb[0];
      n_cmp++; if (out_valid !== 1'b1 || {out_data, out_target, out_source} !== exp) begin n_err++; $display("[TB] FAIL sat_drain: got valid=%b pkt=%h expected pkt=%h", out_valid, {out_data, out_target, out_source}, exp); end
      tick();
      clr_cnt = 1'b0;
    end
    clr_cnt = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd0 || empty !== 1'b1) begin n_err++; $display("[TB] FAIL sat_after: got drop=%0d empty=%b expected 0/1", drop_cnt, empty); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'b0001, PORT, 8'(8'h40 + i));
      tick();
    end
    drive(1'b0, 4'b0001, PORT, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 4'b1000, 8'h77);
    tick();
    drive(1'b0, 4'b0001, PORT, 8'h00);
    n_cmp++; if (level !== 3'd3 || drop_cnt !== 8'd1 || misroute_cnt !== 8'd1) begin n_err++; $display("[TB] FAIL midrst_pre: got level=%0d drop=%0d mis=%0d expected 3/1/1", level, drop_cnt, misroute_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    mdrop = 0;
    mmis  = 0;
    n_cmp++; if (out_valid !== 1'b0 || empty !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_flags: got valid=%b empty=%b expected 0/1", out_valid, empty); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("[TB] FAIL midrst_level: got %0d expected 0", level); end
    n_cmp++; if (drop_cnt !== 8'd0 || misroute_cnt !== 8'd0) begin n_err++; $display("[TB] FAIL midrst_counters: got %0d/%0d expected 0/0", drop_cnt, misroute_cnt); end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 4'b0100, PORT, 8'h5C);
    tick();
    drive(1'b0, 4'b0100, PORT, 8'h00);
    exp = {8'h5C, PORT, 4'b0100};
    n_cmp++; if (out_valid !== 1'b1 || {out_data, out_target, out_source} !== exp) begin n_err++; $display("[TB] FAIL midrst_push: got valid=%b pkt=%h expected pkt=%h", out_valid, {out_data, out_target, out_source}, exp); end
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("[TB] FAIL midrst_push_level: got %0d expected 1", level); end
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_fill_overflow();
    test_push_pop_full();
    test_misroute_clear();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
